// File: rtl/reg_write_arbiter.sv
// Arbitrates the register-file write port between pipeline write-back and an
// auxiliary long-latency result source, using a one-entry pending buffer.
module reg_write_arbiter #(
    parameter int ADDR_SIZE    = 5,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_we,
    input  logic [ADDR_SIZE-1:0]  wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  aux_valid,
    output logic                  aux_ready,
    input  logic [ADDR_SIZE-1:0]  aux_addr,
    input  logic [DATA_WIDTH-1:0] aux_data,
    output logic                  stall_pipe,
    output logic                  reg_d_we,
    output logic [ADDR_SIZE-1:0]  reg_d_addr,
    output logic [DATA_WIDTH-1:0] reg_d_data,
    output logic                  pend_valid,
    output logic [ADDR_SIZE-1:0]  pend_addr
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        EMPTY,
        PENDING,
        FORCE
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_SIZE-1:0]    buf_addr_q, buf_addr_d;
    logic [DATA_WIDTH-1:0]   buf_data_q, buf_data_d;
    logic [CNT_W-1:0]        cnt_inc;
    logic                    wr_we;

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        wr_we      = wb_we;
        reg_d_addr = wb_addr;
        reg_d_data = wb_data;
        aux_ready  = 1'b0;
        stall_pipe = 1'b0;
        case (state_q)
            EMPTY: begin
                aux_ready = 1'b1;
                // Results aimed at register zero complete the handshake but are dropped.
                if (aux_valid && (aux_addr != '0)) begin
                    buf_addr_d = aux_addr;
                    buf_data_d = aux_data;
                    cnt_d      = '0;
                    state_d    = PENDING;
                end
            end
            PENDING: begin
                if (!wb_we) begin
                    wr_we      = 1'b1;
                    reg_d_addr = buf_addr_q;
                    reg_d_data = buf_data_q;
                    cnt_d      = '0;
                    state_d    = EMPTY;
                end else if (wb_addr == buf_addr_q) begin
                    // The pipeline write is newer, so the buffered value is obsolete.
                    cnt_d   = '0;
                    state_d = EMPTY;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(STARVE_LIMIT)) begin
                        state_d = FORCE;
                    end
                end
            end
            FORCE: begin
                stall_pipe = 1'b1;
                wr_we      = 1'b1;
                reg_d_addr = buf_addr_q;
                reg_d_data = buf_data_q;
                cnt_d      = '0;
                state_d    = EMPTY;
            end
            default: begin
                cnt_d   = '0;
                state_d = EMPTY;
            end
        endcase
    end

    assign reg_d_we   = wr_we & ~rst;
    assign pend_valid = (state_q != EMPTY);
    assign pend_addr  = pend_valid ? buf_addr_q : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            cnt_q      <= '0;
            buf_addr_q <= '0;
            buf_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            buf_addr_q <= buf_addr_d;
            buf_data_q <= buf_data_d;
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Randomized and directed bench for reg_write_arbiter, checked against a
// transaction-level model of the pending buffer and its starvation rule.
module tb_reg_write_arbiter;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wb_we;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          aux_valid;
    logic          aux_ready;
    logic [AW-1:0] aux_addr;
    logic [DW-1:0] aux_data;
    logic          stall_pipe;
    logic          reg_d_we;
    logic [AW-1:0] reg_d_addr;
    logic [DW-1:0] reg_d_data;
    logic          pend_valid;
    logic [AW-1:0] pend_addr;

    int total = 0;
    int bad   = 0;

    // Reference model: the waiting result and how many writes it has lost to.
    logic [AW-1:0] q_addr[$];
    logic [DW-1:0] q_data[$];
    int            lost;

    reg_write_arbiter #(
        .ADDR_SIZE   (AW),
        .DATA_WIDTH  (DW),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .aux_valid (aux_valid),
        .aux_ready (aux_ready),
        .aux_addr  (aux_addr),
        .aux_data  (aux_data),
        .stall_pipe(stall_pipe),
        .reg_d_we  (reg_d_we),
        .reg_d_addr(reg_d_addr),
        .reg_d_data(reg_d_data),
        .pend_valid(pend_valid),
        .pend_addr (pend_addr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        q_addr.delete();
        q_data.delete();
        lost = 0;
    endtask

    // Drive one cycle of inputs, compare every output with the model, then advance the model.
    task automatic applyStimulus(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                 input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad);
        logic          e_we, e_stall, e_ready, e_pv;
        logic [AW-1:0] e_addr, e_paddr;
        logic [DW-1:0] e_data;
        bit            waiting;
        @(negedge clk);
        wb_we = we; wb_addr = wa; wb_data = wd;
        aux_valid = av; aux_addr = aa; aux_data = ad;
        #1;
        waiting = (q_addr.size() != 0);
        e_ready = !waiting;
        e_pv    = waiting;
        e_paddr = waiting ? q_addr[0] : '0;
        e_stall = 1'b0;
        e_we = we; e_addr = wa; e_data = wd;
        if (waiting && lost == LIMIT) begin
            e_stall = 1'b1;
            e_we = 1'b1; e_addr = q_addr[0]; e_data = q_data[0];
            modelReset();
        end else if (waiting) begin
            if (!we) begin
                e_we = 1'b1; e_addr = q_addr[0]; e_data = q_data[0];
                modelReset();
            end else if (wa == q_addr[0]) begin
                modelReset();
            end else begin
                lost++;
            end
        end else if (av && aa != 0) begin
            q_addr.push_back(aa);
            q_data.push_back(ad);
            lost = 0;
        end
        checkOutput("aux_ready", 64'(aux_ready), 64'(e_ready));
        checkOutput("stall_pipe", 64'(stall_pipe), 64'(e_stall));
        checkOutput("reg_d_we", 64'(reg_d_we), 64'(e_we));
        checkOutput("reg_d_addr", 64'(reg_d_addr), 64'(e_addr));
        checkOutput("reg_d_data", 64'(reg_d_data), 64'(e_data));
        checkOutput("pend_valid", 64'(pend_valid), 64'(e_pv));
        checkOutput("pend_addr", 64'(pend_addr), 64'(e_paddr));
    endtask

    initial begin
        rst = 1'b1;
        wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'h1;
        aux_valid = 1'b0; aux_addr = '0; aux_data = '0;
        modelReset();
        #12;
        checkOutput("rst_we", 64'(reg_d_we), 64'd0);
        checkOutput("rst_pend", 64'(pend_valid), 64'd0);
        checkOutput("rst_stall", 64'(stall_pipe), 64'd0);
        checkOutput("rst_ready", 64'(aux_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] idle drain");
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF);
        checkOutput("idle_ready", 64'(aux_ready), 64'd1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        checkOutput("idle_addr", 64'(reg_d_addr), 64'd5);
        checkOutput("idle_data", 64'(reg_d_data), 64'hDEADBEEF);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        checkOutput("idle_empty", 64'(pend_valid), 64'd0);

        $display("[TB] priority then drain");
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h77);
        applyStimulus(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'h0);
        checkOutput("prio_addr", 64'(reg_d_addr), 64'd3);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        checkOutput("prio_drain", 64'(reg_d_addr), 64'd7);

        $display("[TB] starvation");
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99);
        for (int i = 0; i < LIMIT; i++) begin
            applyStimulus(1'b1, 5'd2, 32'h20 + i, 1'b0, 5'd0, 32'h0);
            checkOutput("starve_wb", 64'(reg_d_addr), 64'd2);
        end
        applyStimulus(1'b1, 5'd2, 32'h2F, 1'b0, 5'd0, 32'h0);
        checkOutput("force_stall", 64'(stall_pipe), 64'd1);
        checkOutput("force_addr", 64'(reg_d_addr), 64'd9);
        applyStimulus(1'b1, 5'd2, 32'h2F, 1'b0, 5'd0, 32'h0);
        checkOutput("after_stall", 64'(stall_pipe), 64'd0);
        checkOutput("after_addr", 64'(reg_d_addr), 64'd2);

        $display("[TB] WAW and zero address");
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h44);
        applyStimulus(1'b1, 5'd4, 32'h22, 1'b0, 5'd0, 32'h0);
        checkOutput("waw_data", 64'(reg_d_data), 64'h22);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h55);
        checkOutput("waw_dropped", 64'(reg_d_we), 64'd0);
        checkOutput("zero_ready", 64'(aux_ready), 64'd1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        checkOutput("zero_nopend", 64'(pend_valid), 64'd0);

        $display("[TB] reset mid-operation");
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hCC);
        applyStimulus(1'b1, 5'd1, 32'h1, 1'b0, 5'd0, 32'h0);
        applyStimulus(1'b1, 5'd1, 32'h2, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        wb_we = 1'b1; wb_addr = 5'd1;
        rst = 1'b1;
        #1;
        checkOutput("midrst_pend", 64'(pend_valid), 64'd0);
        checkOutput("midrst_we", 64'(reg_d_we), 64'd0);
        modelReset();
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        checkOutput("postrst_we", 64'(reg_d_we), 64'd0);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom(),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
Shares the single register-file write port between the pipeline write-back stage and a long-latency auxiliary result source, such as a multi-cycle multiply/divide unit. The block sits between the write stage and the register file. The pipeline normally has priority. Auxiliary results wait in a one-entry pending buffer, and a starvation limit forces a one-cycle pipeline stall so a waiting result can drain. The block also exports the pending entry so upstream hazard logic can see it.

Parameters:
ADDR_SIZE, 5, register address width
DATA_WIDTH, 32, register data width
STARVE_LIMIT, 4, lost arbitration cycles before a forced drain (must be ≥1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
wb_we  input  1  write-stage write enable
wb_addr  input  ADDR_SIZE  write-stage destination
wb_data  input  DATA_WIDTH  write-stage data
aux_valid  input  1  auxiliary result valid
aux_ready  output  1  auxiliary result accepted this cycle
aux_addr  input  ADDR_SIZE  auxiliary destination
aux_data  input  DATA_WIDTH  auxiliary data
stall_pipe  output  1  freeze MEM/WB; write-stage request re-presented next cycle
reg_d_we  output  1  register-file write enable
reg_d_addr  output  ADDR_SIZE  register-file write address
reg_d_data  output  DATA_WIDTH  register-file write data
pend_valid  output  1  pending buffer occupied
pend_addr  output  ADDR_SIZE  pending destination (0 when empty)

Behaviour:
- Clock, reset and decided interface: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values:
  - state=EMPTY, cnt=0, buffer cleared.
  - stall_pipe=0, pend_valid=0, pend_addr=0.
  - reg_d_we is forced to 0 while rst is high.
- Registered state: state, cnt (width clog2(STARVE_LIMIT+1)), buffer address and buffer data. All other outputs are combinational from state and inputs.
- aux_ready=1 only in EMPTY, so at most one auxiliary result is accepted every 2 cycles.
- State EMPTY:
  - reg_d_* = wb_* (reg_d_we = wb_we).
  - aux_valid & aux_addr≠0: capture aux_addr/aux_data, cnt←0, next state PENDING.
  - aux_valid & aux_addr==0: handshake completes, result discarded, stay EMPTY.
- State PENDING (pend_valid=1):
  - wb_we==0: drive reg_d_* from the buffer with reg_d_we=1; next state EMPTY, cnt←0.
  - wb_we==1 & wb_addr==pend_addr (WAW, pipeline write is newer): reg_d_* = wb_*; buffer dropped; next state EMPTY.
  - wb_we==1 & wb_addr≠pend_addr: reg_d_* = wb_*; cnt←cnt+1. If cnt+1==STARVE_LIMIT, next state FORCE; otherwise stay PENDING.
- State FORCE:
  - stall_pipe=1 for exactly this cycle.
  - reg_d_* driven from the buffer, reg_d_we=1; wb_* is ignored.
  - Next state EMPTY, cnt←0.
  - The pipeline holds MEM/WB, so its write is presented again next cycle.
- Port usage: exactly one writer per cycle; the register file never sees two writes in one cycle.
- Drain latency: a buffered result reaches the register file in the first cycle with wb_we=0, or at most STARVE_LIMIT+1 cycles after capture.
- Reset mid-operation: a pending entry is lost. No write occurs during reset. Outputs reach reset values asynchronously.

Test Plan:
- Reset: assert rst with wb_we=1 → reg_d_we=0, pend_valid=0, stall_pipe=0, aux_ready=1.
- Idle drain:
  - Cycle 0: aux_valid=1, aux_addr=5, aux_data=0xDEADBEEF, wb_we=0 → aux_ready=1.
  - Cycle 1: pend_valid=1, pend_addr=5, reg_d_we=1, reg_d_addr=5, reg_d_data=0xDEADBEEF.
  - Cycle 2: pend_valid=0.
- Priority then drain:
  - Capture aux addr 7.
  - Next cycle: wb_we=1, wb_addr=3, wb_data=0x11 → reg_d_addr=3, reg_d_data=0x11, pend_valid stays 1.
  - Following cycle: wb_we=0 → reg_d_addr=7.
- Starvation:
  - Capture aux addr 9, then hold wb_we=1 with wb_addr=2 for 4 cycles → reg_d_addr=2 in each of those cycles.
  - 5th cycle: stall_pipe=1, reg_d_addr=9.
  - 6th cycle: stall_pipe=0, reg_d_addr=2.
- WAW and zero address:
  - Capture aux addr 4, then wb_we=1, wb_addr=4, wb_data=0x22 → reg_d_data=0x22; pend_valid=0 next cycle; the buffered value is never written.
  - aux_valid with aux_addr=0 → aux_ready=1, pend_valid stays 0.
- Reset mid-operation: assert rst while PENDING with cnt=2 → pend_valid=0 immediately; after release, wb_we=0 gives reg_d_we=0.
